lt_uint_serial: RTL and testbench

- Sequential, digit-serial unsigned less-than comparator. Computes Y = (A < B), the opposite direction of the combinational greater-than borrow chain.
- Runs the same borrow recurrence, LSB-first, one DIGIT-bit slice per clock. This trades latency for area in PIM-style synthesis flows.
- Sits between operand producers and result consumers, with valid/ready handshakes on both sides.

---
 rtl/lt_uint_serial.sv | 176 +++++++++++++++++
 tb/tb_lt_uint_serial.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lt_uint_serial.sv
// lt_uint_serial: digit-serial unsigned comparator, Y = (A < B).
// Walks the borrow chain of A - B, LSB-first, DIGIT bits per clock.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_ready  operand handshake for A, B (WIDTH bits each)
//   out_valid, out_ready result handshake for Y (1 when A < B)
//   EQ                  1 when A == B; present only with LT_UINT_SERIAL_EQ_EN
// Optional feature macro: LT_UINT_SERIAL_EQ_EN
module lt_uint_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef LT_UINT_SERIAL_EQ_EN
   output logic             EQ,
`endif
   output logic             Y
);

   localparam int NUM_DIGITS = WIDTH / DIGIT;
   localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

   generate
      if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
         $error("lt_uint_serial: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             y_q, y_d;
   logic             borrow_n;
   logic             accept;
   logic             last;
   logic [DIGIT-1:0] a_dig;
   logic [DIGIT-1:0] b_dig;

   assign accept = in_valid && in_ready;
   assign last   = (cnt_q == LAST);
   assign a_dig  = a_q[DIGIT-1:0];
   assign b_dig  = b_q[DIGIT-1:0];

`ifdef LT_UINT_SERIAL_EQ_EN
   logic             any_q, any_d;
   logic             any_n;
   logic             eq_q, eq_d;
   logic [DIGIT-1:0] diff;
   logic [DIGIT:0]   sub;

   assign sub = {1'b0, a_dig} - {1'b0, b_dig}
              - {{DIGIT{1'b0}}, borrow_q};
   assign {borrow_n, diff} = sub;
   // Once any digit differs the operands can never be equal.
   assign any_n = any_q | (|diff);
`else
   // Borrow-out of a_dig - b_dig - borrow_q.
   assign borrow_n = (a_dig < b_dig) ||
                     ((a_dig == b_dig) && borrow_q);
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept) state_d = S_RUN;
         S_RUN:  if (last) state_d = S_DONE;
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      in_ready  = (state_q == S_IDLE) && !rst;
      out_valid = (state_q == S_DONE);
      Y         = y_q;
   end

`ifdef LT_UINT_SERIAL_EQ_EN
   assign EQ = eq_q;
`endif

   // Datapath next-state
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      y_d      = y_q;
`ifdef LT_UINT_SERIAL_EQ_EN
      any_d    = any_q;
      eq_d     = eq_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               a_d      = A;
               b_d      = B;
               borrow_d = 1'b0;
               cnt_d    = '0;
`ifdef LT_UINT_SERIAL_EQ_EN
               any_d    = 1'b0;
`endif
            end
         end
         S_RUN: begin
            a_d      = a_q >> DIGIT;
            b_d      = b_q >> DIGIT;
            borrow_d = borrow_n;
            cnt_d    = cnt_q + CW'(1);
`ifdef LT_UINT_SERIAL_EQ_EN
            any_d    = any_n;
`endif
            if (last) begin
               y_d = borrow_n;
`ifdef LT_UINT_SERIAL_EQ_EN
               eq_d = !any_n;
`endif
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         y_q      <= 1'b0;
`ifdef LT_UINT_SERIAL_EQ_EN
         any_q    <= 1'b0;
         eq_q     <= 1'b0;
`endif
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         y_q      <= y_d;
`ifdef LT_UINT_SERIAL_EQ_EN
         any_q    <= any_d;
         eq_q     <= eq_d;
`endif
      end
   end

endmodule

// File: tb/tb_lt_uint_serial.sv
// tb_lt_uint_serial: scoreboard bench for lt_uint_serial.
// Five instances: W8/D1, W32/D4, W16/D16, W16/D2, W16/D1.
module tb_lt_uint_serial;

   localparam int N = 5;

   logic clk = 1'b0;
   logic rst;
   logic [N-1:0] iv, ir, ov, ordy, y;
`ifdef LT_UINT_SERIAL_EQ_EN
   logic [N-1:0] eq;
`endif
   logic [7:0]  a0, b0;
   logic [31:0] a1, b1;
   logic [15:0] a2, b2, a3, b3, a4, b4;

   // {eq, lt} expected per instance, in acceptance order
   logic [1:0] expq [N][$];
   logic [1:0] mon_e;
   int tests = 0;
   int fails = 0;
   bit rnd_mode = 1'b0;

   always #5 clk = ~clk;

   lt_uint_serial #(.WIDTH(8), .DIGIT(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
      .A(a0), .B(b0), .out_valid(ov[0]), .out_ready(ordy[0]),
`ifdef LT_UINT_SERIAL_EQ_EN
      .EQ(eq[0]),
`endif
      .Y(y[0]));

   lt_uint_serial #(.WIDTH(32), .DIGIT(4)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
      .A(a1), .B(b1), .out_valid(ov[1]), .out_ready(ordy[1]),
`ifdef LT_UINT_SERIAL_EQ_EN
      .EQ(eq[1]),
`endif
      .Y(y[1]));

   lt_uint_serial #(.WIDTH(16), .DIGIT(16)) u2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
      .A(a2), .B(b2), .out_valid(ov[2]), .out_ready(ordy[2]),
`ifdef LT_UINT_SERIAL_EQ_EN
      .EQ(eq[2]),
`endif
      .Y(y[2]));

   lt_uint_serial #(.WIDTH(16), .DIGIT(2)) u3 (
      .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
      .A(a3), .B(b3), .out_valid(ov[3]), .out_ready(ordy[3]),
`ifdef LT_UINT_SERIAL_EQ_EN
      .EQ(eq[3]),
`endif
      .Y(y[3]));

   lt_uint_serial #(.WIDTH(16), .DIGIT(1)) u4 (
      .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]),
      .A(a4), .B(b4), .out_valid(ov[4]), .out_ready(ordy[4]),
`ifdef LT_UINT_SERIAL_EQ_EN
      .EQ(eq[4]),
`endif
      .Y(y[4]));

   function automatic int wd(int k);
      case (k)
         0: return 8;
         1: return 32;
         default: return 16;
      endcase
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_ops(int k, logic [31:0] av, logic [31:0] bv);
      case (k)
         0: begin a0 = av[7:0];  b0 = bv[7:0];  end
         1: begin a1 = av;       b1 = bv;       end
         2: begin a2 = av[15:0]; b2 = bv[15:0]; end
         3: begin a3 = av[15:0]; b3 = bv[15:0]; end
         default: begin a4 = av[15:0]; b4 = bv[15:0]; end
      endcase
   endtask

   // Present a pair, hold until accepted, then scramble the operand
   // inputs so a design that keeps sampling them is caught.
   task automatic send(int k, logic [31:0] av, logic [31:0] bv, bit push);
      logic [31:0] m;
      logic [31:0] am, bm;
      bit acc;
      int n;
      m = (wd(k) == 32) ? 32'hFFFF_FFFF : ((32'd1 << wd(k)) - 32'd1);
      am = av & m;
      bm = bv & m;
      set_ops(k, av, bv);
      iv[k] = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 1000) begin
         @(negedge clk);
         acc = ir[k];
         @(posedge clk);
         #1;
         n++;
      end
      iv[k] = 1'b0;
      set_ops(k, $urandom, $urandom);
      if (!acc) begin
         tests++;
         fails++;
         $display("FAIL send_timeout inst %0d: got no accept, expected accept", k);
      end else if (push) begin
         expq[k].push_back({am == bm, am < bm});
      end
   endtask

   task automatic drain();
      int n;
      int pend;
      n = 0;
      pend = 0;
      for (int k = 0; k < N; k++) pend += expq[k].size();
      while (pend != 0 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
         pend = 0;
         for (int k = 0; k < N; k++) pend += expq[k].size();
      end
      chk("drain_pending", pend, 0);
   endtask

   task automatic rnd_run(int k, int cnt);
      logic [31:0] av, bv;
      int sel;
      for (int i = 0; i < cnt; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         av = $urandom;
         bv = $urandom;
         sel = $urandom_range(0, 4);
         if (sel == 0) bv = av;
         else if (sel == 1) av = 32'd0;
         else if (sel == 2) bv = 32'd0;
         send(k, av, bv, 1'b1);
      end
   endtask

   // Monitor: one pop per result handshake
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            if (ov[k] && ordy[k]) begin
               if (expq[k].size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_result inst %0d: got Y=%0b, expected none",
                           k, y[k]);
               end else begin
                  mon_e = expq[k].pop_front();
                  chk($sformatf("y_inst%0d", k), y[k], mon_e[0]);
`ifdef LT_UINT_SERIAL_EQ_EN
                  chk($sformatf("eq_inst%0d", k), eq[k], mon_e[1]);
`endif
               end
            end
         end
      end
   end

   // Random backpressure during the random phase
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_mode) begin
            for (int k = 2; k < N; k++) ordy[k] = ($urandom_range(0, 3) != 0);
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int pulses;
      rst = 1'b1;
      iv = '0;
      ordy = '0;
      for (int k = 0; k < N; k++) set_ops(k, 32'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         chk("rst_out_valid", ov[k], 0);
         chk("rst_y", y[k], 0);
         chk("rst_in_ready", ir[k], 0);
      end
      rst = 1'b0;
      #1;
      for (int k = 0; k < N; k++) chk("idle_in_ready", ir[k], 1);

      // 5 < 9, 8-cycle latency, one-cycle pulse
      ordy[0] = 1'b1;
      send(0, 32'd5, 32'd9, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("t1_out_valid_c%0d", i), ov[0], (i == 8));
      end
      chk("t1_y", y[0], 1);
      @(posedge clk);
      #1;
      chk("t1_pulse_end", ov[0], 0);
      chk("t1_in_ready", ir[0], 1);
      chk("t1_y_hold", y[0], 1);

      // Reset in the third RUN cycle
      send(0, 32'hC8, 32'hC9, 1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", ir[0], 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("mid_rst_out_valid", ov[0], 0);
      chk("mid_rst_y", y[0], 0);
      chk("mid_rst_in_ready", ir[0], 1);
      pulses = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (ov[0]) pulses++;
      end
      chk("mid_rst_no_pulse", pulses, 0);
      send(0, 32'd1, 32'd2, 1'b1);
      drain();

      // 8-bit directed
      send(0, 32'd9, 32'd5, 1'b1);
      send(0, 32'd0, 32'd0, 1'b1);
      send(0, 32'd0, 32'd255, 1'b1);
      send(0, 32'd255, 32'd254, 1'b1);
      drain();

      // 32-bit, DIGIT=4, with backpressure
      ordy[1] = 1'b0;
      send(1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
      n = 0;
      while (!ov[1] && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("w32_latency", n, 8);
      set_ops(1, 32'h8000_0000, 32'h7FFF_FFFF);
      iv[1] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_out_valid", ov[1], 1);
         chk("bp_y", y[1], 1);
         chk("bp_in_ready", ir[1], 0);
      end
      ordy[1] = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_out_valid", ov[1], 0);
      chk("bp_release_in_ready", ir[1], 1);
      @(posedge clk);
      #1;
      chk("bp_accept", ir[1], 0);
      expq[1].push_back(2'b00);
      iv[1] = 1'b0;
      set_ops(1, $urandom, $urandom);
      send(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      send(1, 32'h0000_0000, 32'h0000_0001, 1'b1);
      send(1, 32'h1234_5678, 32'h1234_5679, 1'b1);
      drain();

      // DIGIT = WIDTH: single RUN cycle
      ordy[2] = 1'b1;
      send(2, 32'd0, 32'd1, 1'b1);
      @(posedge clk);
      #1;
      chk("dw_latency", ov[2], 1);
      chk("dw_y", y[2], 1);
      send(2, 32'd123, 32'd0, 1'b1);
      send(2, 32'hFFFF, 32'hFFFF, 1'b1);
      drain();

      // Random pairs with random backpressure
      rnd_mode = 1'b1;
      fork
         rnd_run(2, 333);
         rnd_run(3, 333);
         rnd_run(4, 334);
      join
      rnd_mode = 1'b0;
      ordy = '1;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
